// File: rtl/flex_down_timer.sv
// rtl/flex_down_timer.sv - loadable down-counting timer with one-shot and periodic expiry
module flex_down_timer #(
    parameter int NUM_CNT_BITS = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [NUM_CNT_BITS-1:0] load_val,
    input  logic                    auto_reload,
    input  logic                    count_enable,
    input  logic                    abort,
    output logic [NUM_CNT_BITS-1:0] count_out,
    output logic                    busy,
    output logic                    expire_pulse,
    output logic                    done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [NUM_CNT_BITS-1:0] CNT_ZERO = '0;
    localparam logic [NUM_CNT_BITS-1:0] CNT_ONE  = {{(NUM_CNT_BITS-1){1'b0}}, 1'b1};

    state_t                  state;
    logic [NUM_CNT_BITS-1:0] reload_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            count_out    <= CNT_ZERO;
            reload_reg   <= CNT_ZERO;
            busy         <= 1'b0;
            expire_pulse <= 1'b0;
            done         <= 1'b0;
        end else begin
            expire_pulse <= 1'b0;
            if (abort) begin
                state     <= IDLE;
                count_out <= CNT_ZERO;
                busy      <= 1'b0;
                done      <= 1'b0;
            end else if (start) begin
                // A zero load expires immediately as a one-shot, even in periodic mode.
                if (load_val != CNT_ZERO) begin
                    state      <= RUN;
                    count_out  <= load_val;
                    reload_reg <= load_val;
                    busy       <= 1'b1;
                    done       <= 1'b0;
                end else begin
                    state        <= DONE;
                    count_out    <= CNT_ZERO;
                    expire_pulse <= 1'b1;
                    busy         <= 1'b0;
                    done         <= 1'b1;
                end
            end else begin
                case (state)
                    RUN: begin
                        if (count_enable) begin
                            if (count_out > CNT_ONE) begin
                                count_out <= count_out - CNT_ONE;
                            end else begin
                                expire_pulse <= 1'b1;
                                if (auto_reload) begin
                                    count_out <= reload_reg;
                                end else begin
                                    state     <= DONE;
                                    count_out <= CNT_ZERO;
                                    busy      <= 1'b0;
                                    done      <= 1'b1;
                                end
                            end
                        end
                    end
                    IDLE, DONE: begin
                        count_out <= CNT_ZERO;
                    end
                    default: begin
                        state     <= IDLE;
                        count_out <= CNT_ZERO;
                        busy      <= 1'b0;
                        done      <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
